// File: rtl/usb_rx_ctrl.sv
// USB receive packet controller: tracks SYNC, PID and payload bytes of one
// packet, strobes payload bytes into the receive FIFO and reports packet end
// or error. All outputs come straight from registers.
module usb_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned EOP_MAX   = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [3:0] rx_pid,
  output logic       pid_valid,
  output logic       rx_done,
  output logic [6:0] byte_count
);

  localparam logic [6:0] MaxBytesW = 7'(MAX_BYTES);
  localparam logic [3:0] EopMaxW   = 4'(EOP_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StPid,
    StData,
    StEopWait,
    StDone,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] eop_cnt_q, eop_cnt_d;
  logic [3:0] eop_cnt_inc;
  // Set once eop has been seen while in StError; the line is idle after it drops.
  logic       err_eop_q, err_eop_d;

  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       r_error_q, r_error_d;
  logic [3:0] rx_pid_q, rx_pid_d;
  logic       pid_valid_q, pid_valid_d;
  logic       rx_done_q, rx_done_d;
  logic [6:0] byte_count_q, byte_count_d;

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    eop_cnt_d    = eop_cnt_q;
    err_eop_d    = 1'b0;
    w_enable_d   = 1'b0;
    r_error_d    = r_error_q;
    rx_pid_d     = rx_pid_q;
    pid_valid_d  = pid_valid_q;
    byte_count_d = byte_count_q;
    // One extra bit so an over-long SE0 is caught instead of wrapping.
    eop_cnt_inc  = {1'b0, eop_cnt_q} + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (d_edge) begin
          state_d      = StSync;
          r_error_d    = 1'b0;
          pid_valid_d  = 1'b0;
          byte_count_d = 7'd0;
        end
      end
      StSync: begin
        if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? StPid : StError;
        end else if (eop) begin
          state_d = StError;
        end
      end
      StPid: begin
        if (byte_received) begin
          if (rcv_data[3:0] == ~rcv_data[7:4]) begin
            state_d     = StData;
            rx_pid_d    = rcv_data[3:0];
            pid_valid_d = 1'b1;
          end else begin
            state_d = StError;
          end
        end else if (eop) begin
          state_d = StError;
        end
      end
      StData: begin
        if (byte_received) begin
          // Truncated byte, overflow and length limit all drop the byte.
          if (eop || fifo_full || (byte_count_q >= MaxBytesW)) begin
            state_d = StError;
          end else begin
            w_enable_d   = 1'b1;
            byte_count_d = byte_count_q + 7'd1;
          end
        end else if (eop) begin
          state_d   = StEopWait;
          eop_cnt_d = 3'd0;
        end
      end
      StEopWait: begin
        if (!eop) begin
          state_d = (eop_cnt_q != 3'd0) ? StDone : StError;
        end else if (shift_enable) begin
          eop_cnt_d = eop_cnt_inc[2:0];
          if (eop_cnt_inc > EopMaxW) begin
            state_d = StError;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        err_eop_d = err_eop_q | eop;
        if (!eop && err_eop_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StError) begin
      r_error_d = 1'b1;
    end

    rcving_d  = (state_d == StSync) || (state_d == StPid) ||
                (state_d == StData) || (state_d == StEopWait);
    rx_done_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      eop_cnt_q    <= 3'd0;
      err_eop_q    <= 1'b0;
      rcving_q     <= 1'b0;
      w_enable_q   <= 1'b0;
      r_error_q    <= 1'b0;
      rx_pid_q     <= 4'h0;
      pid_valid_q  <= 1'b0;
      rx_done_q    <= 1'b0;
      byte_count_q <= 7'd0;
    end else begin
      state_q      <= state_d;
      eop_cnt_q    <= eop_cnt_d;
      err_eop_q    <= err_eop_d;
      rcving_q     <= rcving_d;
      w_enable_q   <= w_enable_d;
      r_error_q    <= r_error_d;
      rx_pid_q     <= rx_pid_d;
      pid_valid_q  <= pid_valid_d;
      rx_done_q    <= rx_done_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign rcving     = rcving_q;
  assign w_enable   = w_enable_q;
  assign r_error    = r_error_q;
  assign rx_pid     = rx_pid_q;
  assign pid_valid  = pid_valid_q;
  assign rx_done    = rx_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl: a packet-level model predicts every
// output each cycle, and directed packets pin key results with literals.
module tb_usb_rx_ctrl;

  localparam logic [7:0] Sync  = 8'h80;
  localparam int         MaxB  = 64;
  localparam int         EopM  = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       fifo_full = 1'b0;
  logic       rcving, w_enable, r_error, pid_valid, rx_done;
  logic [3:0] rx_pid;
  logic [6:0] byte_count;

  int n_checks = 0;
  int n_errors = 0;
  int wen_cnt  = 0;
  int done_cnt = 0;

  usb_rx_ctrl #(
    .SYNC_BYTE(Sync),
    .MAX_BYTES(MaxB),
    .EOP_MAX  (EopM)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .rcv_data     (rcv_data),
    .fifo_full    (fifo_full),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .rx_pid       (rx_pid),
    .pid_valid    (pid_valid),
    .rx_done      (rx_done),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  logic       exp_rcving = 1'b0;
  logic       exp_w_enable = 1'b0;
  logic       exp_r_error = 1'b0;
  logic [3:0] exp_rx_pid = 4'h0;
  logic       exp_pid_valid = 1'b0;
  logic       exp_rx_done = 1'b0;
  int         exp_count = 0;
  bit         m_active = 0;   // inside a packet
  bit         m_err = 0;      // packet failed, waiting for idle line
  bit         m_err_eop = 0;
  bit         m_tail = 0;     // in the SE0 end-of-packet phase
  bit         m_done = 0;
  int         m_nbytes = 0;   // bytes seen this packet (sync, pid, payload)
  int         m_eopbits = 0;

  task automatic m_fail();
    m_active    = 0;
    m_tail      = 0;
    m_err       = 1;
    m_err_eop   = 0;
    exp_r_error = 1'b1;
  endtask

  task automatic m_step();
    exp_w_enable = 1'b0;
    exp_rx_done  = 1'b0;
    if (m_done) begin
      m_done = 0;
    end else if (m_err) begin
      if (eop) m_err_eop = 1;
      else if (m_err_eop) m_err = 0;
    end else if (!m_active) begin
      if (d_edge) begin
        m_active      = 1;
        m_tail        = 0;
        m_nbytes      = 0;
        exp_r_error   = 1'b0;
        exp_pid_valid = 1'b0;
        exp_count     = 0;
      end
    end else if (m_tail) begin
      if (!eop) begin
        if (m_eopbits >= 1) begin
          m_active    = 0;
          m_tail      = 0;
          m_done      = 1;
          exp_rx_done = 1'b1;
        end else begin
          m_fail();
        end
      end else if (shift_enable) begin
        m_eopbits++;
        if (m_eopbits > EopM) m_fail();
      end
    end else if (byte_received) begin
      if (m_nbytes == 0) begin
        if (rcv_data != Sync) m_fail();
      end else if (m_nbytes == 1) begin
        if (rcv_data[3:0] == ~rcv_data[7:4]) begin
          exp_rx_pid    = rcv_data[3:0];
          exp_pid_valid = 1'b1;
        end else begin
          m_fail();
        end
      end else if (eop || fifo_full || exp_count == MaxB) begin
        m_fail();
      end else begin
        exp_w_enable = 1'b1;
        exp_count++;
      end
      m_nbytes++;
    end else if (eop) begin
      if (m_nbytes < 2) begin
        m_fail();
      end else begin
        m_tail    = 1;
        m_eopbits = 0;
      end
    end
    exp_rcving = m_active;
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_rcving = 1'b0; exp_w_enable = 1'b0; exp_r_error = 1'b0; exp_rx_pid = 4'h0;
      exp_pid_valid = 1'b0; exp_rx_done = 1'b0; exp_count = 0;
      m_active = 0; m_err = 0; m_err_eop = 0; m_tail = 0; m_done = 0;
      m_nbytes = 0; m_eopbits = 0;
    end else begin
      m_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rcving", 8'(rcving), 8'(exp_rcving));
    check("w_enable", 8'(w_enable), 8'(exp_w_enable));
    check("r_error", 8'(r_error), 8'(exp_r_error));
    check("rx_pid", 8'(rx_pid), 8'(exp_rx_pid));
    check("pid_valid", 8'(pid_valid), 8'(exp_pid_valid));
    check("rx_done", 8'(rx_done), 8'(exp_rx_done));
    check("byte_count", 8'(byte_count), 8'(exp_count));
    if (w_enable) wen_cnt++;
    if (rx_done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    d_edge        = 1'b0;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic start_pkt();
    wen_cnt  = 0;
    done_cnt = 0;
    d_edge   = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ff, input logic e);
    rcv_data      = b;
    fifo_full     = ff;
    eop           = e;
    byte_received = 1'b1;
    tick();
    fifo_full = 1'b0;
    tick();
    tick();
  endtask

  task automatic eop_tail(input int n_se);
    eop = 1'b1;
    tick();
    for (int i = 0; i < n_se; i++) begin
      shift_enable = 1'b1;
      tick();
      tick();
    end
    eop = 1'b0;
    tick();
    tick();
  endtask

  task automatic line_idle();
    eop = 1'b1;
    tick();
    tick();
    eop = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rcving"}, 8'(rcving), 8'h00);
    check({tag, "_w_enable"}, 8'(w_enable), 8'h00);
    check({tag, "_r_error"}, 8'(r_error), 8'h00);
    check({tag, "_rx_pid"}, 8'(rx_pid), 8'h00);
    check({tag, "_pid_valid"}, 8'(pid_valid), 8'h00);
    check({tag, "_rx_done"}, 8'(rx_done), 8'h00);
    check({tag, "_byte_count"}, 8'(byte_count), 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();

    // Bad sync byte
    start_pkt();
    check("start_rcving", 8'(rcving), 8'h01);
    send_byte(8'h81, 1'b0, 1'b0);
    check("badsync_r_error", 8'(r_error), 8'h01);
    check("badsync_rcving", 8'(rcving), 8'h00);
    line_idle();
    check("badsync_wen", 8'(wen_cnt), 8'd0);

    // Bad PID
    start_pkt();
    check("restart_clears_err", 8'(r_error), 8'h00);
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC4, 1'b0, 1'b0);
    check("badpid_r_error", 8'(r_error), 8'h01);
    check("badpid_pid_valid", 8'(pid_valid), 8'h00);
    check("badpid_rx_pid", 8'(rx_pid), 8'h00);
    line_idle();

    // Good packet
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    eop_tail(2);
    check("good_wen", 8'(wen_cnt), 8'd2);
    check("good_done", 8'(done_cnt), 8'd1);
    check("good_rx_pid", 8'(rx_pid), 8'h03);
    check("good_pid_valid", 8'(pid_valid), 8'h01);
    check("good_byte_count", 8'(byte_count), 8'd2);
    check("good_r_error", 8'(r_error), 8'h00);

    // FIFO overflow on second payload byte
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    line_idle();
    check("ovf_wen", 8'(wen_cnt), 8'd1);
    check("ovf_byte_count", 8'(byte_count), 8'd1);
    check("ovf_r_error", 8'(r_error), 8'h01);

    // Payload length limit
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hD2, 1'b0, 1'b0);
    for (int i = 0; i < 65; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
    end
    line_idle();
    check("len_wen", 8'(wen_cnt), 8'd64);
    check("len_byte_count", 8'(byte_count), 8'd64);
    check("len_r_error", 8'(r_error), 8'h01);
    check("len_rx_pid", 8'(rx_pid), 8'h02);

    // SE0 lasting too long
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    eop_tail(5);
    check("longeop_r_error", 8'(r_error), 8'h01);
    check("longeop_done", 8'(done_cnt), 8'd0);

    // eop coincident with a byte in DATA
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b1);
    eop = 1'b0;
    tick();
    tick();
    check("trunc_r_error", 8'(r_error), 8'h01);
    check("trunc_wen", 8'(wen_cnt), 8'd1);
    check("trunc_byte_count", 8'(byte_count), 8'd1);

    // Reset in the middle of DATA, then a fresh packet
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    rcv_data      = 8'hA5;
    byte_received = 1'b1;
    tick();
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    n_rst   = 1'b1;
    wen_cnt = 0;
    repeat (4) tick();
    check("postreset_wen", 8'(wen_cnt), 8'd0);
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'h4B, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    eop_tail(1);
    check("after_wen", 8'(wen_cnt), 8'd1);
    check("after_done", 8'(done_cnt), 8'd1);
    check("after_rx_pid", 8'(rx_pid), 8'h0B);
    check("after_byte_count", 8'(byte_count), 8'd1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
